// File: rtl/clock_ctrl.sv
// 24-hour h:m:s timekeeper with a two-button hour/minute set mode.
// It also produces a blink mask that flashes the field being set.
module clock_ctrl #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] h,
    output logic [5:0] m,
    output logic [5:0] s,
    output logic [5:0] blank,
    output logic [1:0] mode,
    output logic       sec_tick
);

    localparam int PW   = $clog2(CLK_HZ);
    localparam int HALF = CLK_HZ / 2;
    localparam int BW   = $clog2(HALF);
    localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } mode_t;

    mode_t         state_r, state_s;
    logic [4:0]    h_r, h_s;
    logic [5:0]    m_r, m_s;
    logic [5:0]    s_r, s_s;
    logic [5:0]    blank_r, blank_s;
    logic          tick_r, tick_s;
    logic [PW-1:0] pre_r, pre_s;
    logic [BW-1:0] blink_r, blink_s;
    logic          phase_r, phase_s;
    logic          mode_hist_r, inc_hist_r;
    logic          mode_press_s, inc_press_s;

    function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] top);
        return (v == top) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_wrap5(input logic [4:0] v, input logic [4:0] top);
        return (v == top) ? 5'd0 : v + 5'd1;
    endfunction

    assign mode_press_s = btn_mode & ~mode_hist_r;
    assign inc_press_s  = btn_inc & ~inc_hist_r;

    // Next-state logic: mode sequencing, timekeeping, field setting and blink.
    always_comb begin
        state_s = state_r;
        h_s     = h_r;
        m_s     = m_r;
        s_s     = s_r;
        pre_s   = pre_r;
        tick_s  = 1'b0;
        blink_s = blink_r;
        phase_s = phase_r;
        blank_s = 6'd0;

        if (state_r != RUN) begin
            if (blink_r == BLINK_MAX) begin
                blink_s = {BW{1'b0}};
                phase_s = ~phase_r;
            end else begin
                blink_s = blink_r + BW'(1);
                phase_s = phase_r;
            end
        end else begin
            blink_s = blink_r;
            phase_s = phase_r;
        end

        case (state_r)
            RUN: begin
                if (mode_press_s) begin
                    state_s = SET_H;
                    s_s     = 6'd0;
                    pre_s   = {PW{1'b0}};
                    blink_s = {BW{1'b0}};
                    phase_s = 1'b0;
                end else if (pre_r == PRE_MAX) begin
                    pre_s  = {PW{1'b0}};
                    tick_s = 1'b1;
                    s_s    = inc_wrap6(s_r, 6'd59);
                    // Carry ripples in one edge so 23:59:59 -> 00:00:00 is atomic.
                    if (s_r == 6'd59) begin
                        m_s = inc_wrap6(m_r, 6'd59);
                        if (m_r == 6'd59) begin
                            h_s = inc_wrap5(h_r, 5'd23);
                        end else begin
                            h_s = h_r;
                        end
                    end else begin
                        m_s = m_r;
                    end
                end else begin
                    pre_s = pre_r + PW'(1);
                end
            end
            SET_H: begin
                pre_s = {PW{1'b0}};
                s_s   = 6'd0;
                if (mode_press_s) begin
                    state_s = SET_M;
                end else if (inc_press_s) begin
                    h_s     = inc_wrap5(h_r, 5'd23);
                    blink_s = {BW{1'b0}};
                    phase_s = 1'b0;
                end else begin
                    h_s = h_r;
                end
            end
            SET_M: begin
                pre_s = {PW{1'b0}};
                s_s   = 6'd0;
                if (mode_press_s) begin
                    state_s = RUN;
                end else if (inc_press_s) begin
                    m_s     = inc_wrap6(m_r, 6'd59);
                    blink_s = {BW{1'b0}};
                    phase_s = 1'b0;
                end else begin
                    m_s = m_r;
                end
            end
            default: begin
                state_s = RUN;
            end
        endcase

        // Mask follows the next state so a mode press updates blank on the same edge.
        case (state_s)
            SET_H:   blank_s = {phase_s, phase_s, 4'b0000};
            SET_M:   blank_s = {2'b00, phase_s, phase_s, 2'b00};
            default: blank_s = 6'd0;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= RUN;
            h_r         <= 5'd0;
            m_r         <= 6'd0;
            s_r         <= 6'd0;
            blank_r     <= 6'd0;
            tick_r      <= 1'b0;
            pre_r       <= {PW{1'b0}};
            blink_r     <= {BW{1'b0}};
            phase_r     <= 1'b0;
            mode_hist_r <= 1'b1;
            inc_hist_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            h_r         <= h_s;
            m_r         <= m_s;
            s_r         <= s_s;
            blank_r     <= blank_s;
            tick_r      <= tick_s;
            pre_r       <= pre_s;
            blink_r     <= blink_s;
            phase_r     <= phase_s;
            mode_hist_r <= btn_mode;
            inc_hist_r  <= btn_inc;
        end
    end

    assign h        = h_r;
    assign m        = m_r;
    assign s        = s_r;
    assign blank    = blank_r;
    assign mode     = state_r;
    assign sec_tick = tick_r;

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Timekeeping and time-setting controller for the six-digit 7-segment clock display. It counts seconds, minutes and hours in 24-hour format from the system clock. It runs a two-button set mode for hours and minutes. It drives the h/m/s binary fields and a per-digit blank mask into the display LED driver, which blinks the field currently being set.

## Interface
- CLK_HZ, 50_000_000, system clock cycles per second; must be ≥ 4.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- btn_mode  input  1  mode button level, already synchronized and debounced upstream.
- btn_inc  input  1  increment button level, already synchronized and debounced upstream.
- h  output  5  hours, 0..23.
- m  output  6  minutes, 0..59.
- s  output  6  seconds, 0..59.
- blank  output  6  per-digit blank mask: bits 1:0 seconds, 3:2 minutes, 5:4 hours; 1 = digit off.
- mode  output  2  0 = RUN, 1 = SET_H, 2 = SET_M; 3 is never produced.
- sec_tick  output  1  one-cycle pulse when s advances in RUN.

## Operation
- Reset (rst_n low at a clock edge) sets the following:
  - h = m = s = 0, mode = RUN, blank = 0, sec_tick = 0.
  - Prescaler = 0, blink counter = 0, blink phase = 0.
  - Both button-history registers = 1, so a button held through reset does not count as a press.
- A press is a rising edge: the current sample is 1 and the previous registered sample is 0. Holding a button produces exactly one press.
- Mode transitions on each btn_mode press: RUN → SET_H → SET_M → RUN.
- Entering SET_H from RUN does the following:
  - Clears s to 0.
  - Clears the prescaler.
  - Clears the blink counter and blink phase.
- SET_M → SET_H is not possible.
- SET_M → RUN clears the prescaler, so the first sec_tick occurs exactly CLK_HZ cycles after the transition edge.
- Behaviour in RUN:
  - The prescaler counts 0..CLK_HZ−1.
  - On the edge where the prescaler equals CLK_HZ−1, it returns to 0, s increments and sec_tick is registered high for one cycle.
  - s wraps 59 → 0 and carries into m. m wraps 59 → 0 and carries into h. h wraps 23 → 0 without carry.
  - 23:59:59 → 00:00:00 completes in a single edge.
- Behaviour in SET_H and SET_M:
  - The prescaler is held at 0, s is held at 0 and sec_tick stays 0.
  - A btn_inc press increments only the selected field, with no carry: h wraps 23 → 0, m wraps 59 → 0.
  - btn_inc presses in RUN are ignored.
- Blink (SET states only):
  - The blink counter counts 0..(CLK_HZ/2)−1 using integer division.
  - At the terminal count the counter returns to 0 and the blink phase toggles.
  - blank[5:4] = {2{phase}} in SET_H; blank[3:2] = {2{phase}} in SET_M.
  - All other blank bits are 0. In RUN, blank = 0.
- A btn_inc press in a SET state also clears the blink counter and blink phase, so the field is visible immediately after adjustment.
- A btn_mode press and a btn_inc press on the same edge: mode wins; the increment is discarded.
- Asserting rst_n low mid-operation (including in a SET state) restores the full reset state on that edge; any partially set value is lost.

## Timing
- All outputs are registered; there are no combinational input → output paths.
- Press latency: a rising level first sampled at edge k updates mode, h, m and blank on edge k. The new values are visible for the following cycle.
- sec_tick is high during the same cycle in which the incremented s is visible.
- Period: sec_tick has a period of exactly CLK_HZ cycles in steady RUN.
- First tick after reset: the first sec_tick occurs CLK_HZ cycles after the first edge with rst_n high.
- The blink phase toggles every CLK_HZ/2 cycles. For odd CLK_HZ the full blink period is 2·(CLK_HZ/2) cycles.
- Width rules:
  - All increments use the field's own width with an explicit compare-and-wrap; no reliance on modulo-2^n overflow.
  - The prescaler width is clog2(CLK_HZ).

## Test plan
All scenarios use CLK_HZ = 10.
- Reset release, then 10 edges in RUN → s = 1 with sec_tick high for one cycle; after 600 edges, s = 0 and m = 1.
- Rollover: set 23:59 via the SET states, return to RUN, run 600 cycles → at 23:59:59 the next tick yields 00:00:00 with h = m = s = 0 on a single edge.
- Set hours:
  - Mode press → mode = 1, s = 0, blank toggles between 6'b110000 and 0 every 5 cycles.
  - 25 inc presses from h = 0 → h = 1.
  - m is unchanged throughout.
- Inc restarts blink: in SET_M, press inc while blank[3:2] = 2'b11 → next cycle blank = 0 and m is incremented by 1 (59 → 0); blank reasserts 5 cycles later.
- Simultaneous mode and inc press in SET_H → mode = 2 and h is unchanged. A btn_inc held high for 20 cycles counts as one press. btn_inc pressed in RUN → no change.
- Reset mid-SET and held-button guard:
  - Reset asserted while in SET_M with btn_mode held high → after release, mode = 0 and h:m:s = 0:0:0.
  - No mode change occurs until btn_mode falls and rises again.
